// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
// button_event : turns a debounced button level into press / release /
//                short-click / auto-repeat pulses plus a held-long level.
// Revision 1.0 : initial release
// ============================================================================
module button_event #(
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int NBITS         = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean_i,
  output logic press_o,
  output logic release_o,
  output logic short_click_o,
  output logic repeat_o,
  output logic long_o,
  output logic step_o
);

  localparam logic [NBITS-1:0] C_HOLD_LAST   = NBITS'(HOLD_CYCLES - 1);
  localparam logic [NBITS-1:0] C_REPEAT_LAST = NBITS'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  state_t           state_q;
  logic [NBITS-1:0] count_q;
  logic             prev_q;
  logic             press_q;
  logic             release_q;
  logic             short_q;
  logic             repeat_q;
  logic             long_q;
  logic             step_q;

  // prev resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      prev_q    <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      repeat_q  <= 1'b0;
      long_q    <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      prev_q    <= clean_i;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clean_i && !prev_q) begin
            press_q <= 1'b1;
            step_q  <= 1'b1;
            count_q <= '0;
            state_q <= S_HELD;
          end
        end
        S_HELD: begin
          if (!clean_i) begin
            release_q <= 1'b1;
            short_q   <= 1'b1;
            count_q   <= '0;
            state_q   <= S_IDLE;
          end else if (count_q == C_HOLD_LAST) begin
            repeat_q <= 1'b1;
            step_q   <= 1'b1;
            long_q   <= 1'b1;
            count_q  <= '0;
            state_q  <= S_REPEAT;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        S_REPEAT: begin
          // A release on the terminal-count edge suppresses that repeat.
          if (!clean_i) begin
            release_q <= 1'b1;
            long_q    <= 1'b0;
            count_q   <= '0;
            state_q   <= S_IDLE;
          end else if (count_q == C_REPEAT_LAST) begin
            repeat_q <= 1'b1;
            step_q   <= 1'b1;
            count_q  <= '0;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: begin
          count_q <= '0;
          long_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign press_o       = press_q;
  assign release_o     = release_q;
  assign short_click_o = short_q;
  assign repeat_o      = repeat_q;
  assign long_o        = long_q;
  assign step_o        = step_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
// tb_button_event : scoreboard bench; stimulus queues expected output events
//                   by edge number, a monitor pops them as the DUT emits them.
// Revision 1.0 : initial release
// ============================================================================
module tb_button_event;

  logic clk;
  logic rst_n;
  logic clean_i;
  logic press_o, release_o, short_click_o, repeat_o, long_o, step_o;

  button_event #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .NBITS        (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clean_i      (clean_i),
    .press_o      (press_o),
    .release_o    (release_o),
    .short_click_o(short_click_o),
    .repeat_o     (repeat_o),
    .long_o       (long_o),
    .step_o       (step_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event vector bits: {press, release, short_click, repeat, step, long}
  localparam logic [5:0] EV_PRESS     = 6'b100010;
  localparam logic [5:0] EV_REL_SHORT = 6'b011000;
  localparam logic [5:0] EV_REPEAT    = 6'b000111;
  localparam logic [5:0] EV_REL_LONG  = 6'b010000;
  localparam logic [5:0] EV_LONG_DROP = 6'b000000;

  typedef struct {
    int         e;
    logic [5:0] v;
  } ev_t;

  ev_t sb[$];
  int  edge_no   = 0;
  int  n_vec     = 0;
  int  n_err     = 0;
  int  cnt_press = 0;
  int  cnt_rel   = 0;
  int  cnt_short = 0;
  int  cnt_step  = 0;

  task automatic expect_ev(input int e, input logic [5:0] v);
    ev_t t;
    t.e = e;
    t.v = v;
    sb.push_back(t);
  endtask

  // Sets clean for the next rising edge, which is edge number edge_no+1.
  task automatic drive(input logic c);
    @(negedge clk);
    clean_i = c;
  endtask

  task automatic check_val(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [5:0] cur;
    cur = {press_o, release_o, short_click_o, repeat_o, step_o, long_o};
    n_vec++;
    if (cur != 6'b0) begin
      n_err++;
      $display("FAIL %s: outputs %b required 000000", name, cur);
    end
  endtask

  // Monitor: any pulse, or a change of long, is an output event.
  initial begin : monitor
    logic [5:0] cur;
    logic       prev_long;
    ev_t        t;
    prev_long = 1'b0;
    forever begin
      @(posedge clk);
      edge_no = edge_no + 1;
      #1;
      cur = {press_o, release_o, short_click_o, repeat_o, step_o, long_o};
      cnt_press += int'(press_o);
      cnt_rel   += int'(release_o);
      cnt_short += int'(short_click_o);
      cnt_step  += int'(step_o);
      if ((cur[5:1] != 5'b0) || (long_o != prev_long)) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: edge %0d outputs %b required none", edge_no, cur);
        end else begin
          t = sb.pop_front();
          if (t.e != edge_no || t.v != cur) begin
            n_err++;
            $display("FAIL event: edge %0d outputs %b required edge %0d outputs %b",
                     edge_no, cur, t.e, t.v);
          end
        end
      end
      prev_long = long_o;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int k;
    rst_n   = 1'b0;
    clean_i = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    drive(1'b0);
    drive(1'b0);

    // Short click: high for 3 edges.
    drive(1'b1); k = edge_no + 1;
    expect_ev(k, EV_PRESS);
    expect_ev(k + 3, EV_REL_SHORT);
    repeat (2) drive(1'b1);
    drive(1'b0);
    drive(1'b0);

    // Long hold k..k+20 with repeats, release at k+21.
    drive(1'b1); k = edge_no + 1;
    expect_ev(k, EV_PRESS);
    expect_ev(k + 8, EV_REPEAT);
    expect_ev(k + 12, EV_REPEAT);
    expect_ev(k + 16, EV_REPEAT);
    expect_ev(k + 20, EV_REPEAT);
    expect_ev(k + 21, EV_REL_LONG);
    repeat (20) drive(1'b1);
    drive(1'b0);
    drive(1'b0);

    // Release at k+7: still a short click.
    drive(1'b1); k = edge_no + 1;
    expect_ev(k, EV_PRESS);
    expect_ev(k + 7, EV_REL_SHORT);
    repeat (6) drive(1'b1);
    drive(1'b0);
    drive(1'b0);

    // Release on the terminal-count edge k+8: release wins, no repeat.
    drive(1'b1); k = edge_no + 1;
    expect_ev(k, EV_PRESS);
    expect_ev(k + 8, EV_REL_SHORT);
    repeat (7) drive(1'b1);
    drive(1'b0);
    drive(1'b0);

    // Hold through k+8: one repeat, long set, then a long release.
    drive(1'b1); k = edge_no + 1;
    expect_ev(k, EV_PRESS);
    expect_ev(k + 8, EV_REPEAT);
    expect_ev(k + 9, EV_REL_LONG);
    repeat (8) drive(1'b1);
    drive(1'b0);
    drive(1'b0);

    // Button held through reset: ignored until released and pressed again.
    @(negedge clk);
    rst_n   = 1'b0;
    clean_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) drive(1'b1);
    repeat (3) drive(1'b0);
    drive(1'b1); k = edge_no + 1;
    expect_ev(k, EV_PRESS);
    expect_ev(k + 2, EV_REL_SHORT);
    drive(1'b1);
    drive(1'b0);
    drive(1'b0);

    // Reset during REPEAT after edge k+13.
    drive(1'b1); k = edge_no + 1;
    expect_ev(k, EV_PRESS);
    expect_ev(k + 8, EV_REPEAT);
    expect_ev(k + 12, EV_REPEAT);
    expect_ev(k + 14, EV_LONG_DROP);
    repeat (13) drive(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_clear");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) drive(1'b1);
    repeat (2) drive(1'b0);
    drive(1'b1); k = edge_no + 1;
    expect_ev(k, EV_PRESS);
    expect_ev(k + 2, EV_REL_SHORT);
    drive(1'b1);
    drive(1'b0);
    drive(1'b0);

    // Rapid toggling: 10 presses, every re-press right after release.
    @(negedge clk);
    cnt_press = 0;
    cnt_rel   = 0;
    cnt_short = 0;
    cnt_step  = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1); k = edge_no + 1;
      expect_ev(k, EV_PRESS);
      expect_ev(k + 2, EV_REL_SHORT);
      drive(1'b1);
      drive(1'b0);
      drive(1'b0);
    end
    repeat (2) @(negedge clk);
    check_val("rapid_press_count", cnt_press, 10);
    check_val("rapid_release_count", cnt_rel, 10);
    check_val("rapid_short_count", cnt_short, 10);
    check_val("rapid_step_count", cnt_step, 10);

    repeat (3) drive(1'b0);
    check_val("scoreboard_leftover", sb.size(), 0);
    while (sb.size() > 0) begin
      ev_t t;
      t = sb.pop_front();
      $display("FAIL missing_event: edge %0d outputs none required %b", t.e, t.v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
